// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states, default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STEP_W = 3;
  localparam int MAX_STEP   = (1 << DEF_STEP_W) - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Barrel stage: shifts/rotates data by 0..2^STEP_W-1 positions, log2 mux layers.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  data,
  input  logic [STEP_W-1:0] mag,
  input  logic [1:0]        op,
  output logic [WIDTH-1:0]  result
);

  // lvl[k] is the value after the first k layers; layer k moves by 2^k when mag[k] is set
  logic [WIDTH-1:0] lvl [STEP_W+1];
  logic             sign;

  assign lvl[0] = data;
  // SRA fill comes from the stage input's MSB; it never changes across layers
  assign sign   = data[WIDTH-1];

  for (genvar k = 0; k < STEP_W; k++) begin : g_layer
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] shifted;

    assign cur = lvl[k];

    // Fixed-distance shift of this layer for the selected op
    always_comb begin
      case (op)
        OP_SLL:  shifted = {cur[WIDTH-1-SH:0], {SH{1'b0}}};
        OP_SRL:  shifted = {{SH{1'b0}}, cur[WIDTH-1:SH]};
        OP_SRA:  shifted = {{SH{sign}}, cur[WIDTH-1:SH]};
        OP_ROL:  shifted = {cur[WIDTH-1-SH:0], cur[WIDTH-1:WIDTH-SH]};
        default: shifted = cur;
      endcase
    end

    assign lvl[k+1] = mag[k] ? shifted : cur;
  end

  assign result = lvl[STEP_W];

endmodule

// File: rtl/shift_sequencer.sv
// Two-requester round-robin shift unit; 0..15-bit shifts done in passes of at most 7.
// Latency: accept edge to rsp_valid = 1 + passes cycles (1..4); one op in flight.
// Backpressure: holds result in DONE until rsp_ready; req_ready only asserted in IDLE.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W,
  parameter int AMT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'((1 << STEP_W) - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, busy_q;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  logic [1:0]       sel_op;
  logic [STEP_W-1:0] step;
  logic [AMT_W-1:0] rem_after;
  logic [WIDTH-1:0] stage_res;

  // Round-robin arbiter: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    accept   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    sel_data = grant_id ? req1_data : req0_data;
    sel_amt  = grant_id ? req1_amt  : req0_amt;
    sel_op   = grant_id ? req1_op   : req0_op;
  end

  // Per-pass step is the remaining amount clipped to what one barrel pass can do
  always_comb begin
    if (remaining_q > STEP_MAX) begin
      step = STEP_MAX[STEP_W-1:0];
    end else begin
      step = remaining_q[STEP_W-1:0];
    end
    rem_after = remaining_q - AMT_W'(step);
  end

  shift_stage #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_stage (
    .data   (work_q),
    .mag    (step),
    .op     (op_q),
    .result (stage_res)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (sel_amt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (rem_after == '0) state_d = ST_DONE;
      ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: load on accept, one barrel pass per SHIFT cycle
  always_comb begin
    work_d       = work_q;
    remaining_d  = remaining_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      work_d       = sel_data;
      remaining_d  = sel_amt;
      op_d         = sel_op;
      id_d         = grant_id;
      last_grant_d = grant_id;
    end else if (state_q == ST_SHIFT) begin
      work_d      = stage_res;
      remaining_d = rem_after;
    end
  end

  // FSM outputs: ready only to the winner and only while idle
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && req0_valid && !grant_id;
    req1_ready = (state_q == ST_IDLE) && req1_valid && grant_id;
  end

  // State and registered outputs; response flags follow the next state so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      work_q       <= '0;
      remaining_q  <= '0;
      op_q         <= OP_SLL;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      work_q       <= work_d;
      remaining_q  <= remaining_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= (state_d == ST_DONE);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = work_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Shared shift unit for the 16-bit RISC datapath. It arbitrates between two requesters (0 = ALU, 1 = address/immediate unit) with round-robin priority and performs 16-bit logical, arithmetic and rotate shifts of 0–15 positions. The shift is built from a barrel stage limited to 0–7 positions per pass, the same 3-bit magnitude as the existing barrel shifter, so amounts above 7 take several passes. The result is returned on a single response channel tagged with the requester id.

## Interface
- WIDTH, 16, data width.
- STEP_W, 3, per-pass shift magnitude width; the maximum step per pass is 2^STEP_W−1 = 7.
- AMT_W, 4, shift amount width, equal to $clog2(WIDTH).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_data / req1_data  in  WIDTH  operand.
- req0_amt / req1_amt  in  AMT_W  shift amount, 0–15.
- req0_op / req1_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  WIDTH  shifted result.
- rsp_id  out  1  id of the requester that issued the operation.
- busy  out  1  high whenever the state is not IDLE.

## Operation
FSM states are IDLE, SHIFT and DONE.
- **IDLE:** the grant is combinational.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not granted last, using the last_grant register.
  - req_ready is high only for the winner, and only in IDLE.
- **Accept** (valid && ready): latch the operand into work, the amount into remaining, the op, and rsp_id; update last_grant.
  - Next state is DONE if amt == 0, otherwise SHIFT.
- **SHIFT:** each cycle computes step = min(remaining, 7), then work <= stage(work, step, op) and remaining <= remaining − step.
  - When remaining − step == 0, go to DONE.
  - Pass count: amt 1–7 takes 1 pass; 8–14 take 2; 15 takes 3 (7+7+1).
- **Op semantics per pass:**
  - SLL fills the vacated positions with 0.
  - SRL fills with 0.
  - SRA fills with work[WIDTH−1]. The sign is invariant across passes, so a multi-pass SRA equals a single shift.
  - ROL rotates left.
- **DONE:** rsp_valid = 1, with rsp_data = work and rsp_id held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - Requests are not accepted in DONE. There is no back-to-back acceptance.
- **Reset values:**
  - state IDLE; rsp_valid 0, rsp_data 0, rsp_id 0, busy 0.
  - req_ready is then purely a function of req_valid in IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
- **Reset mid-operation:** asserting rst in any state aborts the operation. No response is produced and arbitration history is cleared.
- **Request inputs:** changes to a non-granted requester's inputs while the block is busy have no effect. The granted requester's inputs are ignored after the accept edge.

## Timing
- **Latency:** accept edge to the first cycle with rsp_valid high is 1 + passes cycles. That gives 1 cycle for amt 0, 2 for amt 1–7, 3 for amt 8–14, and 4 for amt 15.
- **Return to IDLE:** the response handshake edge returns the block to IDLE. A new request can be accepted in the next cycle, so the minimum spacing between accepts is 2 + passes cycles.
- **Output registering:** rsp_valid, rsp_data, rsp_id and busy are registered outputs. Only req_ready is combinational, from req_valid and state.
- **Simultaneous requests:** with both requests held continuously valid, grants alternate 0, 1, 0, 1…
- **Response backpressure:** holding rsp_ready low stalls in DONE indefinitely with all outputs stable.

## Structure
- **Shared package shift_pkg:**
  - op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL);
  - state enum typedef;
  - the MAX_STEP constant (7).
- **Sub-module shift_stage:** combinational, with inputs data[WIDTH−1:0], mag[STEP_W−1:0] and op[1:0] and output result. It generalises the existing 8-bit barrel shifter to WIDTH bits and all four ops, uses log2 mux layers, and is reusable by the ALU.
- **Top level:** holds the FSM, arbiter, the work/remaining registers and the response registers.

## Test plan
- **Single SLL:** req0: data 16'h00D5, amt 3, SLL → rsp_valid 2 cycles after accept, rsp_data 16'h06A8, rsp_id 0.
- **Multi-pass SRA:** req1: data 16'h8001, amt 15, SRA → 4-cycle latency, rsp_data 16'hFFFF, rsp_id 1. With SRL and the same inputs → 16'h0001.
- **ROL and zero shift:**
  - ROL: data 16'h1234, amt 8 → 16'h3412 after 3 cycles.
  - Zero shift: amt 0, any op → data returned unchanged with 1-cycle latency.
- **Tie arbitration:** both requesters valid continuously after reset → grant order 0, 1, 0, 1. Each rsp_id matches its grant, and the non-granted ready stays low.
- **Backpressure:** rsp_ready held low 5 cycles in DONE → rsp_valid/rsp_data stable, req_ready both low, busy 1. Release → IDLE next cycle.
- **Reset mid-operation:** rst pulsed during SHIFT of an amt 15 op → next cycle is IDLE, rsp_valid 0, busy 0. With both requesters valid, requester 0 is granted first.
